// File: rtl/waveform_uart_serializer.sv
// ----------------------------------------------------------------------------
// waveform_uart_serializer
//
// Streams a captured ADC waveform buffer to the UART transmitter as one framed
// byte stream: HEADER0, HEADER1, then a high byte and a low byte for every
// sample, then an 8-bit checksum (modulo-256 sum of the sample bytes only).
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          capture-complete pulse; begins a frame when idle
//   waveform_flat  captured buffer, sample i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
//                  must stay stable while busy is high
//   tx_data        byte offered to the UART TX
//   tx_valid       tx_data is valid
//   tx_ready       UART TX accepts the byte this cycle
//   busy           frame in progress
//   done           one-cycle pulse after the checksum byte is accepted
// ----------------------------------------------------------------------------
module waveform_uart_serializer #(
    parameter int         NUM_SAMPLES  = 64,
    parameter int         SAMPLE_WIDTH = 14,
    parameter logic [7:0] HEADER0      = 8'hA5,
    parameter logic [7:0] HEADER1      = 8'h5A
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0]  waveform_flat,
    output logic [7:0]                           tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int                IDX_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_SAMP_HI = 3'd3,
        ST_SAMP_LO = 3'd4,
        ST_CKSUM   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t           state_r,    state_nxt_s;
    logic [IDX_W-1:0] idx_r,      idx_nxt_s,    idx_inc_s;
    logic [7:0]       cksum_r,    cksum_nxt_s,  cksum_sum_s;
    logic [7:0]       tx_data_r,  tx_data_nxt_s;
    logic             tx_valid_r, tx_valid_nxt_s;
    logic             busy_r,     busy_nxt_s;
    logic             done_r,     done_nxt_s;
    logic             xfer_s;
    logic [15:0]      samp_cur_s, samp_inc_s;

    // Selects one sample and zero-extends it to 16 bits so [15:8] is the HI byte
    // and [7:0] is the LO byte for any SAMPLE_WIDTH in 9..16.
    function automatic logic [15:0] get_sample(
        input logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0] flat,
        input logic [IDX_W-1:0]                    idx
    );
        get_sample = 16'(flat[int'(idx) * SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    endfunction

    assign xfer_s      = tx_valid_r & tx_ready;
    // Explicit wrap so the index never depends on natural overflow.
    assign idx_inc_s   = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
    assign cksum_sum_s = cksum_r + tx_data_r;
    assign samp_cur_s  = get_sample(waveform_flat, idx_r);
    assign samp_inc_s  = get_sample(waveform_flat, idx_inc_s);

    // Next-state and next-output computation; outputs are loaded into registers
    // on the same edge as the state so everything downstream sees flops.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        cksum_nxt_s    = cksum_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_HDR0;
                    idx_nxt_s      = {IDX_W{1'b0}};
                    cksum_nxt_s    = 8'h00;
                    tx_data_nxt_s  = HEADER0;
                    tx_valid_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b1;
                end else begin
                    tx_valid_nxt_s = 1'b0;
                    busy_nxt_s     = 1'b0;
                end
            end
            ST_HDR0: begin
                if (xfer_s) begin
                    state_nxt_s   = ST_HDR1;
                    tx_data_nxt_s = HEADER1;
                end else begin
                    state_nxt_s   = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (xfer_s) begin
                    state_nxt_s   = ST_SAMP_HI;
                    tx_data_nxt_s = samp_cur_s[15:8];
                end else begin
                    state_nxt_s   = ST_HDR1;
                end
            end
            ST_SAMP_HI: begin
                if (xfer_s) begin
                    state_nxt_s   = ST_SAMP_LO;
                    cksum_nxt_s   = cksum_sum_s;
                    tx_data_nxt_s = samp_cur_s[7:0];
                end else begin
                    state_nxt_s   = ST_SAMP_HI;
                end
            end
            ST_SAMP_LO: begin
                if (xfer_s) begin
                    cksum_nxt_s = cksum_sum_s;
                    if (idx_r == LAST_IDX) begin
                        // Checksum byte already includes the LO byte now leaving.
                        state_nxt_s   = ST_CKSUM;
                        tx_data_nxt_s = cksum_sum_s;
                    end else begin
                        state_nxt_s   = ST_SAMP_HI;
                        idx_nxt_s     = idx_inc_s;
                        tx_data_nxt_s = samp_inc_s[15:8];
                    end
                end else begin
                    state_nxt_s = ST_SAMP_LO;
                end
            end
            ST_CKSUM: begin
                if (xfer_s) begin
                    state_nxt_s    = ST_DONE;
                    tx_data_nxt_s  = 8'h00;
                    tx_valid_nxt_s = 1'b0;
                    done_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s    = ST_CKSUM;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here; no frame is queued.
                state_nxt_s    = ST_IDLE;
                tx_valid_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                idx_nxt_s      = {IDX_W{1'b0}};
                cksum_nxt_s    = 8'h00;
                tx_data_nxt_s  = 8'h00;
                tx_valid_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // State, index, checksum and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            cksum_r    <= 8'h00;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            cksum_r    <= cksum_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_waveform_uart_serializer.sv
// ----------------------------------------------------------------------------
// Bench for waveform_uart_serializer: randomized and directed frames compared
// against a frame model built from the sample array with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_waveform_uart_serializer;

    localparam int NS = 64;
    localparam int SW = 14;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [NS*SW-1:0] waveform_flat;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    logic [SW-1:0] samples [NS];
    logic [7:0]    exp_q [$];

    waveform_uart_serializer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .waveform_flat (waveform_flat),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the sample array and builds the expected byte stream.
    task automatic load_samples();
        int sum = 0;
        exp_q = {};
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < NS; i++) begin
            int v  = int'(samples[i]);
            int hi = v / 256;
            int lo = v % 256;
            waveform_flat[i*SW +: SW] = samples[i];
            exp_q.push_back(8'(hi));
            exp_q.push_back(8'(lo));
            sum = sum + hi + lo;
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    // Runs one full frame from idle. ready_pct: chance of tx_ready per cycle.
    // restart: pulse start again at byte 10 and in the done cycle.
    task automatic run_frame(input string name, input int ready_pct, input bit restart);
        int  n = 0;
        int  cyc = 0;
        int  busy_cyc = 0;
        int  last_xfer = -10;
        bit  seen_done = 1'b0;
        bit  stall_prev = 1'b0;
        logic [7:0] prev_data = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_hdr_valid"}, 32'(tx_valid), 32'd1);
        check({name, "_hdr_data"}, 32'(tx_data), 32'hA5);
        while (!seen_done && cyc < 2000) begin
            if (busy) busy_cyc++;
            if (stall_prev) begin
                check({name, "_stall_valid"}, 32'(tx_valid), 32'd1);
                check({name, "_stall_data"}, 32'(tx_data), 32'(prev_data));
            end
            if (done) begin
                seen_done = 1'b1;
                check({name, "_nbytes"}, 32'(n), 32'(exp_q.size()));
                check({name, "_done_gap"}, 32'(cyc - last_xfer), 32'd1);
                check({name, "_done_busy"}, 32'(busy), 32'd1);
                check({name, "_done_valid"}, 32'(tx_valid), 32'd0);
                start = restart;
            end else begin
                start    = restart && (n == 10);
                tx_ready = ($urandom_range(0, 99) < ready_pct);
                if (tx_valid && tx_ready) begin
                    if (n < exp_q.size())
                        check({name, "_byte"}, 32'(tx_data), 32'(exp_q[n]));
                    else
                        check({name, "_extra_byte"}, 32'(n), 32'(exp_q.size()));
                    n++;
                    last_xfer = cyc;
                end
                stall_prev = tx_valid && !tx_ready;
                prev_data  = tx_data;
                @(negedge clk);
                cyc++;
            end
        end
        check({name, "_done_seen"}, 32'(seen_done), 32'd1);
        if (ready_pct >= 100)
            check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_q.size() + 1));
        @(negedge clk);
        start = 1'b0;
        check({name, "_post_done"}, 32'(done), 32'd0);
        check({name, "_post_busy"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check({name, "_idle_valid"}, 32'(tx_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        tx_ready      = 1'b0;
        waveform_flat = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_no_effect", 32'(tx_valid), 32'd0);

        // Ramp
        for (int i = 0; i < NS; i++) samples[i] = SW'(i);
        load_samples();
        run_frame("ramp", 100, 1'b0);

        // Full scale
        for (int i = 0; i < NS; i++) samples[i] = 14'h3FFF;
        load_samples();
        run_frame("full", 100, 1'b0);

        // Backpressure on ramp data
        for (int i = 0; i < NS; i++) samples[i] = SW'(i);
        load_samples();
        run_frame("bp", 30, 1'b0);

        // start re-pulsed mid-frame and in the done cycle
        run_frame("restart", 100, 1'b1);

        // Reset during SAMP_LO of sample 20 (byte 43 of the stream)
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (43) @(negedge clk);
        check("pre_rst_lo20", 32'(tx_data), 32'd20);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(tx_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame("after_rst", 100, 1'b0);

        // Single non-zero sample
        for (int i = 0; i < NS; i++) samples[i] = 14'h0000;
        samples[0] = 14'h2ABC;
        load_samples();
        run_frame("s0", 100, 1'b0);

        // Random data under random backpressure
        for (int i = 0; i < NS; i++) samples[i] = SW'($urandom);
        load_samples();
        run_frame("rand", 50, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
